// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit count of the slice counter; a 1-bit counter is kept even for WIDTH=1.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fac.sv
// Single-bit full-adder cell: z = x ^ y ^ ci, co = majority(x, y, ci).
module fac (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic z,
  output logic co
);

  assign z  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with start/ready/done handshake, LSB first.
// Defining SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] ps_next;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             cout;

  fac u_fac (
    .x  (sa[0]),
    .y  (sb[0]),
    .ci (c),
    .z  (s),
    .co (cout)
  );

  assign last  = (cnt == CW'(WIDTH - 1));
  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shifting right and then overwriting the MSB also covers WIDTH=1 cleanly.
  always_comb begin
    ps_next            = ps >> 1;
    ps_next[WIDTH-1]   = s;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      ps  <= '0;
      c   <= 1'b0;
      cnt <= '0;
      sum <= '0;
      co  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      c   <= ci;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      ps <= ps_next;
      c  <= cout;
      if (last) begin
        // Result registers move only here, so they hold through IDLE and the next RUN.
        sum <= ps_next;
        co  <= cout;
`ifdef SERIAL_ADDER_OVF_EN
        ovf <= c ^ cout;
`endif
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
